audio_echo: RTL and testbench

Single-tap echo/delay stage between the audio receive and audio send paths of the WM8978 interface. It consumes each received 32-bit sample (`adc_data` qualified by `rx_done`) and stores it in an internal circular delay line. It reads back the sample from `delay` frames earlier and outputs the input plus the gain-scaled delayed sample, saturated, on `dac_data`. `clk` is driven from `aud_bclk` at the top level, so `rx_done` is a one-cycle pulse in this domain.

---
 rtl/audio_echo_if.sv | 13 +
 rtl/audio_echo.sv | 119 +++++++++++
 tb/tb_audio_echo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_echo_if.sv
// Sample stream bundle between the WM8978 receive path, the echo stage and the send path.
// The master modport is the side that supplies received samples and consumes processed ones.
interface audio_echo_if #(
  parameter int WL = 32
);
  logic [WL-1:0] adc_data;
  logic          rx_done;
  logic [WL-1:0] dac_data;
  logic          dac_valid;

  modport master (output adc_data, rx_done, input dac_data, dac_valid);
  modport slave  (input adc_data, rx_done, output dac_data, dac_valid);
endinterface

// File: rtl/audio_echo.sv
// Single-tap echo stage: circular delay line, Q0.8 gain on the delayed tap, saturating add.
// Define AUDIO_ECHO_FEEDBACK_EN to store the saturated output (recirculating echo) instead of the input.
module audio_echo #(
  parameter int AW = 10,
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          sys_rst,
  audio_echo_if.slave   aud,
  input  logic [AW-1:0] delay,
  input  logic [7:0]    gain,
  input  logic          bypass,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   DEPTH_W = {1'b1, {AW{1'b0}}};
  localparam logic [WL-1:0] SAT_MAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] SAT_MIN = {1'b1, {(WL-1){1'b0}}};

  state_t        state_reg;
  logic [WL-1:0] mem [DEPTH];
  logic [WL-1:0] rdata_reg;
  logic [AW-1:0] wptr_reg;
  logic [AW:0]   fill_reg;
  logic [AW:0]   eff_delay_reg;
  logic [WL-1:0] x_reg;
  logic [7:0]    gain_reg;
  logic          bypass_reg;
  logic [WL-1:0] p_reg;

  logic [AW-1:0]  raddr;
  logic           mem_re;
  logic           mem_we;
  logic [WL-1:0]  tap;
  logic [WL+7:0]  tap_ext;
  logic [WL+7:0]  gain_ext;
  logic [WL+7:0]  prod;
  logic [WL-1:0]  p_next;
  logic [WL:0]    sum;
  logic [WL-1:0]  sat_s;
  logic [WL-1:0]  store_word;
  logic           unused_frac;

  // The read is issued on the acceptance edge so the tap is ready when MAC starts.
  assign raddr  = wptr_reg - delay;
  assign mem_re = (state_reg == IDLE) && aud.rx_done && !sys_rst;
  assign mem_we = (state_reg == SAT) && !sys_rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_reg] <= store_word;
    if (mem_re) rdata_reg <= mem[raddr];
  end

  // Locations not yet written since reset read as silence.
  assign tap      = (fill_reg < eff_delay_reg) ? '0 : rdata_reg;
  assign tap_ext  = {{8{tap[WL-1]}}, tap};
  assign gain_ext = {{WL{1'b0}}, gain_reg};
  assign prod     = tap_ext * gain_ext;
  assign p_next   = prod[WL+7:8];
  assign unused_frac = ^prod[7:0];

  always_comb begin
    sum   = {x_reg[WL-1], x_reg} + {p_reg[WL-1], p_reg};
    sat_s = sum[WL-1:0];
    if (sum[WL] != sum[WL-1]) sat_s = sum[WL] ? SAT_MIN : SAT_MAX;
  end

`ifdef AUDIO_ECHO_FEEDBACK_EN
  assign store_word = sat_s;
`else
  assign store_word = x_reg;
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      aud.dac_data  <= '0;
      aud.dac_valid <= 1'b0;
      overrun       <= 1'b0;
      wptr_reg      <= '0;
      fill_reg      <= '0;
      eff_delay_reg <= '0;
      x_reg         <= '0;
      gain_reg      <= '0;
      bypass_reg    <= 1'b0;
      p_reg         <= '0;
    end else begin
      aud.dac_valid <= 1'b0;
      if (aud.rx_done && state_reg != IDLE) overrun <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (aud.rx_done) begin
            x_reg         <= aud.adc_data;
            gain_reg      <= gain;
            bypass_reg    <= bypass;
            eff_delay_reg <= (delay == '0) ? DEPTH_W : {1'b0, delay};
            state_reg     <= MAC;
          end
        end
        MAC: begin
          p_reg     <= p_next;
          state_reg <= SAT;
        end
        SAT: begin
          aud.dac_data  <= bypass_reg ? x_reg : sat_s;
          aud.dac_valid <= 1'b1;
          wptr_reg      <= wptr_reg + 1'b1;
          if (fill_reg != DEPTH_W) fill_reg <= fill_reg + 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_echo.sv
// Directed bench for audio_echo with a 16-deep delay line; expected values are worked by hand.
module tb_audio_echo;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] delay = '0;
  logic [7:0] gain = '0;
  logic       bypass = 1'b0;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  audio_echo_if #(.WL(32)) aud ();

  audio_echo #(.AW(4), .WL(32)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .aud     (aud),
    .delay   (delay),
    .gain    (gain),
    .bypass  (bypass),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    sys_rst = 1'b1;
    aud.rx_done = 1'b0;
    aud.adc_data = '0;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
  endtask

  // One sample: strobe, then wait (bounded) for dac_valid; also reports dac_valid the cycle after.
  task automatic send(input logic [31:0] s, output logic [31:0] out, output int lat,
                      output logic valid_after);
    @(posedge clk); #1;
    aud.adc_data = s;
    aud.rx_done = 1'b1;
    @(posedge clk); #1;
    aud.rx_done = 1'b0;
    lat = 1;
    while (!aud.dac_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    out = aud.dac_data;
    @(posedge clk); #1;
    valid_after = aud.dac_valid;
    $display("tx in=%08h out=%08h latency=%0d", s, out, lat);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    aud.rx_done = 1'b0;
    aud.adc_data = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) sys_rst = 1'b0;
      n_cmp++;
      if (aud.dac_data !== 32'd0 || aud.dac_valid !== 1'b0 || overrun !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: data=%h valid=%b overrun=%b, required 0/0/0",
                 c, aud.dac_data, aud.dac_valid, overrun);
      end
    end
  endtask

  task automatic test_basic_echo();
    logic [31:0] ins [4] = '{32'd1000, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp [4] = '{32'd1000, 32'd0, 32'd500, 32'd0};
    logic [31:0] out;
    int lat;
    logic va;
    do_reset();
    delay = 4'd2; gain = 8'd128; bypass = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(ins[i], out, lat, va);
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL basic_echo[%0d]: got %0d, required %0d", i, out, exp[i]);
      end
      n_cmp++;
      if (lat !== 3) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: got %0d cycles, required 3", i, lat);
      end
      n_cmp++;
      if (va !== 1'b0) begin
        n_err++;
        $display("FAIL valid_width[%0d]: dac_valid=%b the cycle after, required 0", i, va);
      end
    end
  endtask

  task automatic test_fill_masking();
    logic [31:0] out;
    int lat;
    logic va;
    do_reset();
    delay = 4'd0; gain = 8'd255; bypass = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(32'd100, out, lat, va);
      n_cmp++;
      if (out !== 32'd100) begin
        n_err++;
        $display("FAIL fill_mask[%0d]: got %0d, required 100", i, out);
      end
    end
    send(32'd0, out, lat, va);
    n_cmp++;
    if (out !== 32'd99) begin
      n_err++;
      $display("FAIL fill_full_tap: got %0d, required 99", out);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] ins [4] = '{32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] exp [4] = '{32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'hFF7F_FFF0, 32'h8000_0000};
    logic [31:0] out;
    int lat;
    logic va;
    do_reset();
    delay = 4'd1; gain = 8'd255; bypass = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(ins[i], out, lat, va);
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL saturation[%0d]: got %08h, required %08h", i, out, exp[i]);
      end
    end
  endtask

  task automatic test_overrun_bypass();
    logic [31:0] out;
    logic [31:0] vdata;
    int lat;
    int vcount;
    int vcyc;
    logic va;
    do_reset();
    delay = 4'd1; gain = 8'd128; bypass = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    @(posedge clk); #1;
    aud.adc_data = 32'd2000; aud.rx_done = 1'b1;
    @(posedge clk); #1;
    aud.adc_data = 32'd999;
    @(posedge clk); #1;
    aud.rx_done = 1'b0;
    vcount = 0; vcyc = -1; vdata = '0;
    for (int c = 2; c <= 7; c++) begin
      if (aud.dac_valid) begin
        vcount++;
        vcyc = c;
        vdata = aud.dac_data;
      end
      @(posedge clk); #1;
    end
    $display("tx double strobe: valids=%0d at N+%0d data=%0d overrun=%b", vcount, vcyc, vdata, overrun);
    n_cmp++;
    if (vcount !== 1 || vcyc !== 3 || vdata !== 32'd2000) begin
      n_err++;
      $display("FAIL overrun_single: %0d valids at N+%0d data %0d, required 1 at N+3 data 2000",
               vcount, vcyc, vdata);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    bypass = 1'b1;
    send(32'd1234, out, lat, va);
    n_cmp++;
    if (out !== 32'd1234) begin
      n_err++;
      $display("FAIL bypass: got %0d, required 1234", out);
    end
    bypass = 1'b0;
    send(32'd0, out, lat, va);
    n_cmp++;
    if (out !== 32'd617) begin
      n_err++;
      $display("FAIL bypass_line_update: got %0d, required 617", out);
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
    do_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_reset: got %b, required 0", overrun);
    end
  endtask

  task automatic test_feedback();
    logic [31:0] ins [4] = '{32'd1024, 32'd0, 32'd0, 32'd0};
`ifdef AUDIO_ECHO_FEEDBACK_EN
    logic [31:0] exp [4] = '{32'd1024, 32'd512, 32'd256, 32'd128};
`else
    logic [31:0] exp [4] = '{32'd1024, 32'd512, 32'd0, 32'd0};
`endif
    logic [31:0] out;
    int lat;
    logic va;
    do_reset();
    delay = 4'd1; gain = 8'd128; bypass = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(ins[i], out, lat, va);
      n_cmp++;
      if (out !== exp[i]) begin
        n_err++;
        $display("FAIL feedback[%0d]: got %0d, required %0d", i, out, exp[i]);
      end
    end
  endtask

  initial begin
    aud.rx_done = 1'b0;
    aud.adc_data = '0;
    test_reset();
    test_basic_echo();
    test_fill_masking();
    test_saturation();
    test_overrun_bypass();
    test_feedback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
